// File: rtl/dual_issue_queue.sv
// rtl/dual_issue_queue.sv - fetch-to-decode instruction queue with dual-issue slots A/B
// Dual issue is enabled by defining DIQ_DUAL_ISSUE_EN; otherwise slot B is permanently empty.
module dual_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     FetchValid_i,
    input  logic [DATA_WIDTH-1:0]    FetchInstrA_i,
    input  logic [DATA_WIDTH-1:0]    FetchInstrB_i,
    output logic                     FetchReady_o,
    input  logic                     Stall_i,
    input  logic                     Flush_i,
    output logic [DATA_WIDTH-1:0]    InstrA_o,
    output logic [DATA_WIDTH-1:0]    InstrB_o,
    output logic                     ValidA_o,
    output logic                     ValidB_o,
    output logic [$clog2(DEPTH):0]   Count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h00000013);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] slot_a;
    logic                  valid_a;
    logic [DATA_WIDTH-1:0] h0;
    logic                  push;
    logic                  dual;
    logic [CW-1:0]         pop;
    logic [CW-1:0]         pop_eff;

    assign FetchReady_o = (count <= CW'(DEPTH - 2));
    assign push         = FetchValid_i && FetchReady_o;
    assign h0           = mem[head];
    assign Count_o      = count;
    assign InstrA_o     = slot_a;
    assign ValidA_o     = valid_a;

`ifdef DIQ_DUAL_ISSUE_EN
    logic [DATA_WIDTH-1:0] h1;
    logic                  alu_a;
    logic                  alu_b;
    logic                  wr_a;
    logic                  wr_b;
    logic                  raw;
    logic                  waw;
    logic [DATA_WIDTH-1:0] slot_b;
    logic                  valid_b;

    assign h1    = mem[head + PW'(1)];
    assign alu_a = (h0[6:0] == 7'd19) || (h0[6:0] == 7'd51);
    assign alu_b = (h1[6:0] == 7'd19) || (h1[6:0] == 7'd51);
    assign wr_a  = alu_a && (h0[11:7] != 5'd0);
    assign wr_b  = alu_b && (h1[11:7] != 5'd0);
    // rs2 only counts as a source for register-register ops
    assign raw   = wr_a && ((h1[19:15] == h0[11:7]) ||
                            ((h1[6:0] == 7'd51) && (h1[24:20] == h0[11:7])));
    assign waw   = wr_a && wr_b && (h0[11:7] == h1[11:7]);
    assign dual  = (count >= CW'(2)) && alu_a && alu_b && !raw && !waw;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || Flush_i) begin
            slot_b  <= NOP;
            valid_b <= 1'b0;
        end else if (!Stall_i) begin
            slot_b  <= dual ? h1 : NOP;
            valid_b <= dual;
        end
    end

    assign InstrB_o = slot_b;
    assign ValidB_o = valid_b;
`else
    assign dual     = 1'b0;
    assign InstrB_o = NOP;
    assign ValidB_o = 1'b0;
`endif

    assign pop     = (count == '0) ? CW'(0) : (dual ? CW'(2) : CW'(1));
    assign pop_eff = Stall_i ? CW'(0) : pop;

    always_ff @(posedge clk_i) begin
        if (rst_n_i && !Flush_i && push) begin
            mem[tail]          <= FetchInstrA_i;
            mem[tail + PW'(1)] <= FetchInstrB_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            slot_a  <= NOP;
            valid_a <= 1'b0;
        end else if (Flush_i) begin
            head    <= tail;
            count   <= '0;
            slot_a  <= NOP;
            valid_a <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PW'(2);
            end
            if (!Stall_i) begin
                head    <= head + pop[PW-1:0];
                slot_a  <= (count != '0) ? h0 : NOP;
                valid_a <= (count != '0);
            end
            count <= count + (push ? CW'(2) : CW'(0)) - pop_eff;
        end
    end
endmodule

// File: tb/tb_dual_issue_queue.sv
// tb/tb_dual_issue_queue.sv - directed and random checks of dual_issue_queue against a queue model
module tb_dual_issue_queue;
    localparam int DEPTH = 8;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fvalid = 1'b0;
    logic [31:0] fa = '0;
    logic [31:0] fb = '0;
    logic        fready;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr_a;
    logic [31:0] instr_b;
    logic        valid_a;
    logic        valid_b;
    logic [3:0]  cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] q[$];
    logic [31:0] ea = NOP;
    logic [31:0] eb = NOP;
    logic        eva = 1'b0;
    logic        evb = 1'b0;

    dual_issue_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .FetchValid_i(fvalid), .FetchInstrA_i(fa), .FetchInstrB_i(fb),
        .FetchReady_o(fready), .Stall_i(stall), .Flush_i(flush),
        .InstrA_o(instr_a), .InstrB_o(instr_b),
        .ValidA_o(valid_a), .ValidB_o(valid_b), .Count_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_alu(input logic [31:0] i);
        return i[6:0] == 7'd19 || i[6:0] == 7'd51;
    endfunction

    // Pair rule: both arithmetic, B reads nothing A writes, and they don't write the same register.
    function automatic bit pair_ok(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] rd;
        bit a_writes;
        bit b_writes;
        bit reads;
        rd = a[11:7];
        a_writes = is_alu(a) && rd != 0;
        b_writes = is_alu(b) && b[11:7] != 0;
        reads = (b[19:15] == rd) || (b[6:0] == 7'd51 && b[24:20] == rd);
        if (!is_alu(a) || !is_alu(b)) return 0;
        if (a_writes && reads) return 0;
        if (a_writes && b_writes && b[11:7] == rd) return 0;
        return 1;
    endfunction

    function automatic bit dual_build();
`ifdef DIQ_DUAL_ISSUE_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid_a"}, 32'(valid_a), 32'(eva));
        chk({tag, ".instr_a"}, instr_a, ea);
        chk({tag, ".valid_b"}, 32'(valid_b), 32'(evb));
        chk({tag, ".instr_b"}, instr_b, eb);
        chk({tag, ".count"}, 32'(cnt), 32'(q.size()));
        chk({tag, ".ready"}, 32'(fready), 32'((DEPTH - q.size()) >= 2));
    endtask

    task automatic step(input string tag, input bit v, input logic [31:0] a, input logic [31:0] b,
                        input bit st, input bit fl);
        bit ready;
        ready = (DEPTH - q.size()) >= 2;
        if (fl) begin
            q.delete();
            ea = NOP; eva = 0; eb = NOP; evb = 0;
        end else begin
            if (!st) begin
                eb = NOP; evb = 0;
                if (q.size() == 0) begin
                    ea = NOP; eva = 0;
                end else if (dual_build() && q.size() >= 2 && pair_ok(q[0], q[1])) begin
                    ea = q.pop_front(); eva = 1;
                    eb = q.pop_front(); evb = 1;
                end else begin
                    ea = q.pop_front(); eva = 1;
                end
            end
            if (v && ready) begin
                q.push_back(a);
                q.push_back(b);
            end
        end
        fvalid = v; fa = a; fb = b; stall = st; flush = fl;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 32'h0, 32'h0, 0, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 3))
            0: i[6:0] = 7'd19;
            1: i[6:0] = 7'd51;
            2: i[6:0] = 7'd3;
            default: i[6:0] = 7'd35;
        endcase
        if ($urandom_range(0, 7) == 0) i[6:0] = 7'd19;
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        return i;
    endfunction

    initial begin
        // reset held two cycles
        rst_n = 0;
        fvalid = 1; fa = 32'h003100B3; fb = 32'h00128213; stall = 1; flush = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1; fvalid = 0; stall = 0; flush = 0;
        q.delete();
        check_all("reset");

        // independent pair
        step("indep.push", 1, 32'h003100B3, 32'h00128213, 0, 0);
        step("indep.issue1", 0, 32'h0, 32'h0, 0, 0);
        step("indep.issue2", 0, 32'h0, 32'h0, 0, 0);
        idle("indep.drain", 2);

        // RAW split
        step("raw.push", 1, 32'h00500093, 32'h00108133, 0, 0);
        step("raw.issue1", 0, 32'h0, 32'h0, 0, 0);
        step("raw.issue2", 0, 32'h0, 32'h0, 0, 0);
        idle("raw.drain", 2);

        // full queue under stall, then drain in order
        for (int i = 0; i < 5; i++)
            step("full.push", 1, 32'h00000093 | (32'(2*i+1) << 20), 32'h00000113 | (32'(2*i+2) << 20), 1, 0);
        chk("full.count8", 32'(cnt), 32'd8);
        chk("full.ready0", 32'(fready), 32'd0);
        idle("full.drain", 10);

        // wrap the pointers, then flush with a concurrent push at count 6
        for (int i = 0; i < 3; i++) step("wrap.push", 1, rand_instr(), rand_instr(), 0, 0);
        idle("wrap.drain", 6);
        for (int i = 0; i < 3; i++) step("flush.fill", 1, rand_instr(), rand_instr(), 1, 0);
        chk("flush.count6", 32'(cnt), 32'd6);
        step("flush", 1, 32'h003100B3, 32'h00128213, 1, 1);
        idle("flush.after", 2);

        // random traffic
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 2) != 0), rand_instr(), rand_instr(),
                 1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 39) == 0));

        // reset mid-stream discards everything
        for (int i = 0; i < 2; i++) step("mid.fill", 1, rand_instr(), rand_instr(), 1, 0);
        rst_n = 0; fvalid = 1; stall = 0; flush = 0;
        @(posedge clk);
        #1;
        rst_n = 1; fvalid = 0;
        q.delete();
        ea = NOP; eva = 0; eb = NOP; evb = 0;
        check_all("mid.reset");
        idle("mid.after", 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dual_issue_queue.md
# dual_issue_queue

Instruction buffer between instruction fetch and the dual-issue decode/control stage. Accepts fetched instruction pairs, stores them in a circular queue of single-instruction entries, and each cycle issues up to two instructions into registered slots A and B, which drive the control unit's `InstrA_i` and `InstrB_i`. A pair is split, with slot A issuing alone, when slot B depends on slot A or either instruction is outside the arithmetic I/R class. Slot B then moves to slot A on the next issue.

## Interface
- `DATA_WIDTH`, 32, instruction width.
- `DEPTH`, 8, queue entries (single instructions); power of two, ≥4.
---
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `FetchValid_i`  in  1  fetch presents a pair this cycle.
- `FetchInstrA_i`  in  DATA_WIDTH  older instruction of the pair.
- `FetchInstrB_i`  in  DATA_WIDTH  younger instruction of the pair.
- `FetchReady_o`  out  1  queue can accept a pair.
- `Stall_i`  in  1  downstream stall; hold issue slots.
- `Flush_i`  in  1  discard all queued and issued instructions.
- `InstrA_o`  out  DATA_WIDTH  issue slot A (older).
- `InstrB_o`  out  DATA_WIDTH  issue slot B (younger).
- `ValidA_o`  out  1  slot A holds a real instruction.
- `ValidB_o`  out  1  slot B holds a real instruction.
- `Count_o`  out  $clog2(DEPTH)+1  queued entries, excluding the issue slots.

## Operation
- **Queue.** Head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is a separate register.
- **Push.** A push occurs when `FetchValid_i && FetchReady_o`. It writes A at tail and B at tail+1, then advances tail by 2.
- **Ready.** `FetchReady_o` = `(DEPTH - count) >= 2`. It is computed from the registered `count` only; a dequeue in the same cycle is not credited.
- **Issue classification.** An instruction is ALU-class if opcode[6:0] is 7'd19 or 7'd51.
- **Dependency on the pair.**
  - rdA = H0[11:7]; A writes a register if it is ALU-class and rdA≠0.
  - B depends on A if A writes and either:
    - H1[19:15]==rdA, or
    - H1 opcode is 7'd51 and H1[24:20]==rdA.
  - WAW: both write and rdA==rdB.
- **Issue decision** (when `!Stall_i`):
  - count==0 → both slots empty.
  - count==1 → issue H0 to A only.
  - count≥2 and pair dual-issuable → issue H0 to A and H1 to B, pop 2.
    - Dual-issuable means both ALU-class, no dependency, no WAW.
  - Otherwise → H0 to A only, pop 1.
- **Empty slot.** An empty slot drives `32'h00000013` (addi x0,x0,0) with its valid bit at 0.
- **Count update.** `count_next = count + 2·push − pop`. A simultaneous push and pop is legal.

## Timing
- **Reset** (`rst_n_i`=0 at an edge):
  - pointers=0, count=0;
  - `ValidA_o`/`ValidB_o`=0;
  - `InstrA_o`/`InstrB_o`=`32'h00000013`;
  - `FetchReady_o`=1 after the edge.
  - Reset overrides push, flush and stall. Reset mid-stream discards everything.
- **Latency.** A pair pushed at edge N can occupy the issue slots at the earliest after edge N+1. There is no bypass from fetch to the slots.
- **Issue slots.** All issue outputs are registered and update only at edges with `!Stall_i`.
- **Stall.** `Stall_i`=1 holds the slots and performs no pop. A push still proceeds if ready.
- **Flush.** `Flush_i`=1 (with rst_n_i=1) at an edge empties the queue (count=0, head=tail) and sets both slots empty. It has priority over push and stall.
- **Full queue.** `FetchReady_o`=0 when count>DEPTH−2. `FetchValid_i` is then ignored with no state change.
- **Ordering.** Program order is preserved. Slot A is always older than slot B, and B never issues without A.

## Configuration
- `DIQ_DUAL_ISSUE_EN` defined → dual-issue as specified above.
- Undefined → single-issue:
  - at most one pop per cycle;
  - `ValidB_o` tied 0 and `InstrB_o` tied `32'h00000013`;
  - hazard comparators are not synthesised.
- Queue, push and flush behaviour are identical in both builds.

## Test plan
- **Reset.** Hold `rst_n_i`=0 for 2 cycles, then release → `ValidA_o`=`ValidB_o`=0, both instruction outputs `32'h00000013`, `Count_o`=0, `FetchReady_o`=1.
- **Independent pair.** Push `0x003100B3` (add x1,x2,x3) and `0x00128213` (addi x4,x5,1) → after the second edge, A=`0x003100B3`, B=`0x00128213`, both valid, `Count_o`=0.
- **RAW split.** Push `0x00500093` (addi x1,x0,5) and `0x00108133` (add x2,x1,x1) → first issue A=`0x00500093`, `ValidB_o`=0; next issue A=`0x00108133`, `ValidB_o`=0.
- **Full queue.** DEPTH=8, hold `Stall_i`=1 and push 5 pairs back-to-back → `Count_o`=8 and `FetchReady_o`=0 after the 4th pair; the 5th pair is not stored; release the stall → issue resumes in order from the first pair.
- **Flush with wrap.** Push until pointers wrap past DEPTH, reach count=6, then assert `Flush_i` together with `FetchValid_i` → after the edge `Count_o`=0, both valids 0, pushed pair dropped.
- **Build without the macro.** Compile without `DIQ_DUAL_ISSUE_EN` and repeat the independent-pair test → A=`0x003100B3` then A=`0x00128213` on consecutive issues, `ValidB_o` always 0.
